// File: rtl/dbus_sram_responder_pkg.sv
// Shared types for the single-outstanding data bus and the SRAM responder FSM.
package dbus_sram_responder_pkg;

  localparam int DBUS_RESP_LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_WAIT,
    RS_RESP
  } resp_state_t;

  // Data-bus request/response as driven by the CPU memory stage.
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  // Counter preload for a given load latency; latencies 0 and 1 never use the counter.
  function automatic logic [3:0] resp_cnt_init(input int lat);
    if (lat > 1) return 4'(lat - 1);
    return 4'd1;
  endfunction

endpackage

// File: rtl/dbus_sram_responder_array.sv
// Word array behind the dbus responder: asynchronous read, byte-strobed synchronous write, no reset.
module dbus_sram_array #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [3:0]            strb_i,
  input  logic [DEPTH_LOG2-1:0] idx_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dbus_sram_responder.sv
// Single-outstanding dbus responder with programmable load latency over a byte-strobed word array.
// Optional macro DBUS_RESP_STORE_DATA_OK_EN: stores also return data_ok (with data 0) after LATENCY.
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam logic [3:0] CNT_INIT = resp_cnt_init(LATENCY);

  resp_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] cap_q, cap_d;
  logic [31:0] rdata;
  logic        accept;
  logic        is_store;
  logic        tracked;
  logic        unused_req_bits;

  assign accept   = (state_q == RS_IDLE) && dreq.valid && !reset;
  assign is_store = |dreq.strobe;

  // Transfer size and out-of-range address bits are deliberately ignored (word access, aliasing).
  assign unused_req_bits = ^{dreq.size, dreq.addr};

`ifdef DBUS_RESP_STORE_DATA_OK_EN
  assign tracked = 1'b1;
`else
  assign tracked = !is_store;
`endif

  dbus_sram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk_i   (clk),
    .we_i    (accept && is_store),
    .strb_i  (dreq.strobe),
    .idx_i   (dreq.addr[DEPTH_LOG2+1:2]),
    .wdata_i (dreq.data),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RS_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    cap_q <= cap_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    case (state_q)
      RS_IDLE: begin
        if (accept && tracked && (LATENCY != 0)) begin
          cap_d   = is_store ? 32'd0 : rdata;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? RS_RESP : RS_WAIT;
        end
      end
      RS_WAIT: begin
        // Leaving on a count of 1 places data_ok exactly LATENCY cycles after acceptance.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RS_RESP;
      end
      RS_RESP: state_d = RS_IDLE;
      default: state_d = RS_IDLE;
    endcase
  end

  always_comb begin
    dresp = '0;
    case (state_q)
      RS_IDLE: begin
        dresp.addr_ok = dreq.valid && !reset;
        if ((LATENCY == 0) && accept && tracked) begin
          dresp.data_ok = 1'b1;
          dresp.data    = is_store ? 32'd0 : rdata;
        end
      end
      RS_RESP: begin
        dresp.data_ok = 1'b1;
        dresp.data    = cap_q;
      end
      default: dresp = '0;
    endcase
  end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench for dbus_sram_responder across LATENCY 0/1/3 and a small aliasing array.
module tb_dbus_sram_responder;
  import dbus_sram_responder_pkg::*;

  logic       clk = 1'b0;
  logic       rst [4];
  dbus_req_t  req [4];
  dbus_resp_t resp [4];
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dbus_sram_responder #(.DEPTH_LOG2(12), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(rst[0]), .dreq(req[0]), .dresp(resp[0]));
  dbus_sram_responder #(.DEPTH_LOG2(12), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(rst[1]), .dreq(req[1]), .dresp(resp[1]));
  dbus_sram_responder #(.DEPTH_LOG2(12), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(rst[2]), .dreq(req[2]), .dresp(resp[2]));
  dbus_sram_responder #(.DEPTH_LOG2(4), .LATENCY(1)) u_d4 (
    .clk(clk), .reset(rst[3]), .dreq(req[3]), .dresp(resp[3]));

  typedef struct packed {
    logic        is_store;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_resp(input string name, input int i, input logic ao, input logic dk,
                          input logic [31:0] d);
    chk({name, " ok"}, {30'd0, resp[i].addr_ok, resp[i].data_ok}, {30'd0, ao, dk});
    chk({name, " data"}, resp[i].data, d);
  endtask

  task automatic drive(input int i, input logic v, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d);
    req[i].valid  = v;
    req[i].addr   = a;
    req[i].size   = 3'd2;
    req[i].strobe = s;
    req[i].data   = d;
  endtask

  // Tasks start and end 1ns after a rising edge.
  task automatic do_store(input int i, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input string name);
    drive(i, 1'b1, a, s, d);
    @(negedge clk);
    chk_resp(name, i, 1'b1, 1'b0, 32'd0);
    @(posedge clk); #1;
    drive(i, 1'b0, 32'd0, 4'd0, 32'd0);
  endtask

  task automatic do_load(input int i, input int lat, input logic [31:0] a,
                         input logic [31:0] exp, input string name);
    drive(i, 1'b1, a, 4'd0, 32'd0);
    @(negedge clk);
    if (lat == 0) chk_resp(name, i, 1'b1, 1'b1, exp);
    else          chk_resp(name, i, 1'b1, 1'b0, 32'd0);
    @(posedge clk); #1;
    drive(i, 1'b0, 32'd0, 4'd0, 32'd0);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == lat) chk_resp($sformatf("%s +%0d", name, k), i, 1'b0, 1'b1, exp);
      else          chk_resp($sformatf("%s +%0d", name, k), i, 1'b0, 1'b0, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1;
      drive(i, 1'b0, 32'd0, 4'd0, 32'd0);
    end
    drive(1, 1'b1, 32'd0, 4'd0, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk_resp($sformatf("reset%0d", i), i, 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    drive(1, 1'b0, 32'd0, 4'd0, 32'd0);

    // LATENCY=1: store/load, byte strobes, store-then-load in back-to-back cycles.
    vecs.push_back('{1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0});
    vecs.push_back('{1'b0, 32'h100, 4'h0, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{1'b1, 32'h100, 4'hF, 32'h11223344, 32'h0});
    vecs.push_back('{1'b1, 32'h100, 4'h1, 32'h000000AA, 32'h0});
    vecs.push_back('{1'b0, 32'h100, 4'h0, 32'h0,        32'h112233AA});
    vecs.push_back('{1'b1, 32'h104, 4'hF, 32'h00000000, 32'h0});
    vecs.push_back('{1'b1, 32'h104, 4'hC, 32'hCAFE1234, 32'h0});
    vecs.push_back('{1'b1, 32'h104, 4'h2, 32'h77775677, 32'h0});
    vecs.push_back('{1'b0, 32'h104, 4'h0, 32'h0,        32'hCAFE5600});
    vecs.push_back('{1'b0, 32'h100, 4'h0, 32'h0,        32'h112233AA});
    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].is_store)
        do_store(0, vecs[k].addr, vecs[k].strb, vecs[k].data, $sformatf("vec%0d st", k));
      else
        do_load(0, 1, vecs[k].addr, vecs[k].exp, $sformatf("vec%0d ld", k));
    end

    // LATENCY=0: three loads on consecutive cycles.
    do_store(1, 32'h0, 4'hF, 32'hA0A0A0A0, "l0 st0");
    do_store(1, 32'h4, 4'hF, 32'hB1B1B1B1, "l0 st4");
    do_store(1, 32'h8, 4'hF, 32'hC2C2C2C2, "l0 st8");
    do_load(1, 0, 32'h0, 32'hA0A0A0A0, "l0 ld0");
    do_load(1, 0, 32'h4, 32'hB1B1B1B1, "l0 ld4");
    do_load(1, 0, 32'h8, 32'hC2C2C2C2, "l0 ld8");

    // LATENCY=3: busy backpressure with a second request held from t+1.
    do_store(2, 32'h0, 4'hF, 32'h12345678, "l3 st0");
    do_store(2, 32'h4, 4'hF, 32'h9ABCDEF0, "l3 st4");
    drive(2, 1'b1, 32'h0, 4'd0, 32'd0);
    @(negedge clk);
    chk_resp("bp t", 2, 1'b1, 1'b0, 32'd0);
    @(posedge clk); #1;
    drive(2, 1'b1, 32'h4, 4'd0, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k < 3) chk_resp($sformatf("bp t+%0d", k), 2, 1'b0, 1'b0, 32'd0);
      else       chk_resp("bp t+3", 2, 1'b0, 1'b1, 32'h12345678);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk_resp("bp t+4", 2, 1'b1, 1'b0, 32'd0);
    @(posedge clk); #1;
    drive(2, 1'b0, 32'd0, 4'd0, 32'd0);
    for (int k = 5; k <= 7; k++) begin
      @(negedge clk);
      if (k < 7) chk_resp($sformatf("bp t+%0d", k), 2, 1'b0, 1'b0, 32'd0);
      else       chk_resp("bp t+7", 2, 1'b0, 1'b1, 32'h9ABCDEF0);
      @(posedge clk); #1;
    end

    // LATENCY=3: reset in the cycle after a load is accepted drops it.
    drive(2, 1'b1, 32'h4, 4'd0, 32'd0);
    @(negedge clk);
    chk_resp("rst acc", 2, 1'b1, 1'b0, 32'd0);
    @(posedge clk); #1;
    rst[2] = 1'b1;
    drive(2, 1'b1, 32'h0, 4'd0, 32'd0);
    @(negedge clk);
    chk_resp("rst during", 2, 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    rst[2] = 1'b0;
    @(negedge clk);
    chk_resp("rst reacc", 2, 1'b1, 1'b0, 32'd0);
    @(posedge clk); #1;
    drive(2, 1'b0, 32'd0, 4'd0, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k < 3) chk_resp($sformatf("rst post+%0d", k), 2, 1'b0, 1'b0, 32'd0);
      else       chk_resp("rst post+3", 2, 1'b0, 1'b1, 32'h12345678);
      @(posedge clk); #1;
    end

    // DEPTH_LOG2=4: 0x40 aliases onto word 0.
    do_store(3, 32'h40, 4'hF, 32'h00000055, "alias st");
    do_load(3, 1, 32'h00, 32'h00000055, "alias ld");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dbus_sram_responder.md
# dbus_sram_responder

Memory-side responder for the single-outstanding data bus (`dbus_req_t` / `dbus_resp_t`) driven by the CPU memory stage. It accepts one request at a time and backs it with an internal byte-strobed word array. Read data returns after a programmable latency. It serves as the data-memory model for core-level simulation and as the on-chip scratchpad behind the dbus.

## Interface
- `DEPTH_LOG2`, default 12: array holds 2^DEPTH_LOG2 32-bit words.
- `LATENCY`, default 1: cycles from acceptance to `data_ok`. 0 means the same cycle as `addr_ok`. Legal range 0..15.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `dreq`  in  `dbus_req_t`  request: valid, addr, size, strobe, data.
- `dresp`  out  `dbus_resp_t`  response: addr_ok, data_ok, data.

## Operation
- Word index is `dreq.addr[DEPTH_LOG2+1:2]`. Upper address bits are ignored, so addresses alias modulo the array size. `size` is not checked.
- The responder always returns the full word. The initiator performs byte/halfword selection.
- State `RS_IDLE`:
  - `addr_ok` is high combinationally whenever `dreq.valid`. The request is accepted that cycle.
  - Store (`strobe != 0`): bytes with `strobe[i]=1` are written from `dreq.data[8i+7:8i]` at the accepting edge.
  - Load (`strobe == 0`): the word is read combinationally.
  - `LATENCY==0` load: `data_ok=1` with `dresp.data`=word in the same cycle. Stay in `RS_IDLE`.
  - `LATENCY>0` load: capture the word, load counter with `LATENCY-1`, go to `RS_WAIT`, or to `RS_RESP` if `LATENCY==1`.
- State `RS_WAIT`: `addr_ok=0`. The counter decrements each cycle; at 0 go to `RS_RESP`.
- State `RS_RESP`: `data_ok=1` and `dresp.data` = captured word for exactly one cycle. `addr_ok=0`. Next state is `RS_IDLE`.
- Stores complete on `addr_ok` alone when the macro is absent (see Configuration).
- `dresp.data` is 0 whenever `data_ok=0`.
- A load returns data captured at acceptance. Writes arriving later never alter it.
- Array contents are not reset and power up X.

## Timing
- Reset values: `addr_ok=0`, `data_ok=0`, `data=0`, state `RS_IDLE`, counter 0.
- Asserting `reset` mid-transaction drops the pending load; no `data_ok` is ever issued for it.
- Load latency: `data_ok` is asserted LATENCY cycles after the `addr_ok` cycle.
- Throughput:
  - `LATENCY==0`: one request per cycle.
  - Otherwise: one load per LATENCY+1 cycles, and stores one per cycle while in `RS_IDLE`.
- The initiator holds `dreq` stable until `addr_ok`. The responder keeps no memory of unaccepted requests.
- A `dreq.valid` seen in `RS_WAIT` or `RS_RESP` gets `addr_ok=0` and is accepted on the first `RS_IDLE` cycle.
- A store and a load to the same word in consecutive `RS_IDLE` cycles: the load sees the stored bytes.

## Configuration
- `DBUS_RESP_STORE_DATA_OK_EN`: stores follow the same `RS_WAIT`/`RS_RESP` path as loads.
  - The write still occurs at acceptance.
  - `data_ok` is asserted LATENCY cycles later, or the same cycle when LATENCY=0, with `data=0`.
- Without the macro, stores never raise `data_ok`. This is required by initiators that finish stores on `addr_ok`.

## Structure
- Shared package gets:
  - `resp_state_t` enum: `RS_IDLE`, `RS_WAIT`, `RS_RESP`.
  - `DBUS_RESP_LATENCY_MAX = 15` constant.
- `dbus_req_t` and `dbus_resp_t` stay where they are already defined.
- One sub-module, `dbus_sram_array`: 2^DEPTH_LOG2 x 32 array with asynchronous read and a 4-bit byte-strobe synchronous write. It has no reset.
- FSM, counter and capture register live in `dbus_sram_responder`.

## Test plan
- Reset mid-load: LATENCY=3, load accepted, `reset` pulsed in the next cycle -> outputs 0 immediately, no `data_ok` afterward, next request accepted in the first post-reset `RS_IDLE` cycle.
- Basic store/load: LATENCY=1.
  - Store 0xDEADBEEF, strobe 4'hF, addr 0x100 -> `addr_ok` in the same cycle.
  - Load 0x100 -> `addr_ok` in cycle t, `data_ok` in t+1, data 0xDEADBEEF.
- Byte strobe: store 0x000000AA, strobe 4'h1, to 0x100 holding 0x11223344 -> load returns 0x112233AA.
- Zero latency: LATENCY=0, loads to 0x0, 0x4, 0x8 on three consecutive cycles -> `addr_ok` and `data_ok` both high each cycle with the correct words.
- Busy backpressure: LATENCY=3, load accepted at t, second request held from t+1 -> `addr_ok` low t+1..t+3, `data_ok` at t+3, second request accepted at t+4.
- Aliasing: DEPTH_LOG2=4, store 0x55 to addr 0x40 -> load at 0x00 returns the same word.
